// File: rtl/bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : bcd_serial_adder
// Purpose  : Digit-serial packed-BCD adder, one decimal digit per clock, LSD first.
// Revision : 1.0  initial release
// ============================================================================
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

    logic [1:0]          state_q, state_d;
    logic [4*DIGITS-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [2:0]          idx_q, idx_d;
    logic                carry_q, carry_d;
    logic                cout_q, cout_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [3:0] w_dig_a, w_dig_b, w_dig_sum;
    logic [4:0] w_raw;
    logic       w_dig_carry;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        err_d   = err_q;
        w_dig_a = 4'd0;
        w_dig_b = 4'd0;

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                w_dig_a = a_q[4*i +: 4];
                w_dig_b = b_q[4*i +: 4];
            end
        end

        // carry_q is preloaded with cin at capture, so digit 0 needs no special case
        w_raw = {1'b0, w_dig_a} + {1'b0, w_dig_b} + {4'd0, carry_q};
        if (w_raw > 5'd9) begin
            w_dig_sum   = w_raw[3:0] + 4'd6;
            w_dig_carry = 1'b1;
        end else begin
            w_dig_sum   = w_raw[3:0];
            w_dig_carry = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = 3'd0;
                    err_d   = 1'b0;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == 3'(i)) begin
                        sum_d[4*i +: 4] = w_dig_sum;
                    end
                end
                carry_d = w_dig_carry;
                if ((w_dig_a > 4'd9) || (w_dig_b > 4'd9)) begin
                    err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    cout_d  = w_dig_carry;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags registered from the next state so they align with it exactly
        busy_d = (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= 3'd0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_serial_adder
// Purpose  : Directed self-checking bench for bcd_serial_adder (DIGITS=4).
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
    logic        done;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; launches one op and returns at the negedge where done is seen.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                         output int cyc, output int bcnt, output logic tout);
        a     = ta;
        b     = tb_v;
        cin   = tc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc  = 0;
        bcnt = 0;
        tout = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
            if (done) begin
                tout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc, bcnt;
        logic tout;
        rst_n = 1'b0;
        start = 1'b0;
        a = 16'h0; b = 16'h0; cin = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({sum, cout, busy, done, err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 00000", {sum, cout, busy, done, err});
        end
        // start sampled on the very first edge after release
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0000, 16'h0000, 1'b1, cyc, bcnt, tout);
        n_tests++;
        if (tout || sum !== 16'h0001 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL first_edge_start: timeout=%0b sum=%h cout=%0b required sum=0001 cout=0", tout, sum, cout);
        end
    endtask

    task automatic test_basic();
        int cyc, bcnt;
        logic tout;
        @(negedge clk);
        do_op(16'h1234, 16'h5678, 1'b0, cyc, bcnt, tout);
        n_tests++;
        if (tout || sum !== 16'h6912 || cout !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_sum: timeout=%0b sum=%h cout=%0b err=%0b required 6912/0/0", tout, sum, cout, err);
        end
        n_tests++;
        if (cyc !== DIGITS + 1 || bcnt !== DIGITS) begin
            n_fail++;
            $display("FAIL basic_latency: done_cycle=%0d busy_cycles=%0d required %0d/%0d", cyc, bcnt, DIGITS + 1, DIGITS);
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h6912) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%0b busy=%0b sum=%h required 0/0/6912", done, busy, sum);
        end
    endtask

    task automatic test_carry();
        int cyc, bcnt;
        logic tout;
        @(negedge clk);
        do_op(16'h9999, 16'h0001, 1'b0, cyc, bcnt, tout);
        n_tests++;
        if (tout || sum !== 16'h0000 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_ripple: sum=%h cout=%0b required 0000/1", sum, cout);
        end
        @(negedge clk);
        do_op(16'h9999, 16'h9999, 1'b1, cyc, bcnt, tout);
        n_tests++;
        if (tout || sum !== 16'h9999 || cout !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_max: sum=%h cout=%0b required 9999/1", sum, cout);
        end
        @(negedge clk);
        do_op(16'h0500, 16'h0500, 1'b0, cyc, bcnt, tout);
        n_tests++;
        if (tout || sum !== 16'h1000 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_mid: sum=%h cout=%0b required 1000/0", sum, cout);
        end
    endtask

    task automatic test_err();
        int cyc, bcnt;
        logic tout;
        @(negedge clk);
        do_op(16'h12A4, 16'h0000, 1'b0, cyc, bcnt, tout);
        n_tests++;
        if (tout || err !== 1'b1 || sum !== 16'h1304 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL err_flag: err=%0b sum=%h cout=%0b required 1/1304/0", err, sum, cout);
        end
        @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_hold: err=%0b required 1", err);
        end
        do_op(16'h0011, 16'h0022, 1'b0, cyc, bcnt, tout);
        n_tests++;
        if (tout || err !== 1'b0 || sum !== 16'h0033) begin
            n_fail++;
            $display("FAIL err_clear: err=%0b sum=%h required 0/0033", err, sum);
        end
    endtask

    task automatic test_ignore_start();
        int ndone;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 2) begin
                a = 16'h1111; b = 16'h1111; cin = 1'b1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) ndone++;
        end
        start = 1'b0;
        n_tests++;
        if (ndone !== 1 || sum !== 16'h6912) begin
            n_fail++;
            $display("FAIL ignore_start: dones=%0d sum=%h required 1/6912", ndone, sum);
        end
    endtask

    task automatic test_reset_mid();
        int ndone, cyc, bcnt;
        logic tout;
        @(negedge clk);
        a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sum, cout, busy, done, err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h required 00000", {sum, cout, busy, done, err});
        end
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (k == 2) rst_n = 1'b1;
        end
        n_tests++;
        if (ndone !== 0 || sum !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_mid_abort: dones=%0d sum=%h required 0/0000", ndone, sum);
        end
        do_op(16'h0500, 16'h0500, 1'b0, cyc, bcnt, tout);
        n_tests++;
        if (tout || sum !== 16'h1000 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_recover: timeout=%0b sum=%h cout=%0b required 1000/0", tout, sum, cout);
        end
    endtask

    task automatic test_back_to_back();
        int first, second, nd;
        @(negedge clk);
        a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
        first = -1; second = -1; nd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                if (nd == 0) first = k;
                else if (nd == 1) second = k;
                nd++;
            end
        end
        start = 1'b0;
        n_tests++;
        if (nd < 2 || (second - first) !== DIGITS + 2) begin
            n_fail++;
            $display("FAIL back_to_back_gap: dones=%0d gap=%0d required >=2/%0d", nd, second - first, DIGITS + 2);
        end
        n_tests++;
        if (sum !== 16'h0003 || cout !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_sum: sum=%h cout=%0b required 0003/0", sum, cout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_err();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        repeat (10) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
